// File: rtl/score_pkg.sv
// Shared types and helpers for the multi-digit score renderer.
package score_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_DRAW,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Smallest value that no longer fits in n decimal digits.
    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    function automatic int glyph_base(input int digit, input int pix_per_glyph);
        return digit * pix_per_glyph;
    endfunction

endpackage

// File: rtl/score_renderer_bcd_dabble.sv
// Sequential shift-add-3 binary to BCD converter, one shift per cycle.
// Out-of-range inputs produce all nines after the same number of cycles.
module bcd_dabble
    import score_pkg::*;
#(
    parameter int SCORE_W    = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic [SCORE_W-1:0]      bin_i,
    output logic                    busy_o,
    output logic                    valid_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               sat_q, sat_d;
    logic [BCD_W-1:0]   adj;
    logic               last;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        last   = busy_q && (cnt_q == CNT_W'(SCORE_W - 1));
        bcd_d  = bcd_q;
        bin_d  = bin_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        sat_d  = sat_q;
        if (load_i) begin
            bcd_d  = '0;
            bin_d  = bin_i;
            cnt_d  = '0;
            busy_d = 1'b1;
            sat_d  = (longint'(bin_i) >= pow10(NUM_DIGITS));
        end else if (busy_q) begin
            bcd_d = {adj[BCD_W-2:0], bin_q[SCORE_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
                if (sat_q) begin
                    bcd_d = {NUM_DIGITS{4'h9}};
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            sat_q  <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            bin_q  <= bin_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            sat_q  <= sat_d;
        end
    end

    // valid_o marks the final shift cycle; bcd_o holds the result from the next cycle on.
    assign busy_o  = busy_q;
    assign valid_o = last;
    assign bcd_o   = bcd_q;

endmodule

// File: rtl/score_renderer.sv
// Converts a binary score to BCD and scans each digit glyph from an external
// ROM, emitting one pixel write per glyph pixel with leading-zero blanking.
module score_renderer
    import score_pkg::*;
#(
    parameter int                  NUM_DIGITS = 4,
    parameter int                  SCORE_W    = 14,
    parameter int                  GLYPH_W    = 16,
    parameter int                  GLYPH_H    = 32,
    parameter int                  GAP        = 2,
    parameter int                  COLOUR_W   = 3,
    parameter int                  X_W        = 8,
    parameter int                  Y_W        = 7,
    parameter int                  BLANK_LZ   = 1,
    parameter logic [COLOUR_W-1:0] BG_COLOUR  = '0,
    parameter int                  ROM_AW     = 13
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [SCORE_W-1:0]  score,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    localparam int C_W           = $clog2(GLYPH_W);
    localparam int R_W           = $clog2(GLYPH_H);
    localparam int D_W           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PIX_PER_GLYPH = GLYPH_W * GLYPH_H;

    state_t                  state_q, state_d;
    logic [D_W-1:0]          d_q, d_d;
    logic [R_W-1:0]          r_q, r_d;
    logic [C_W-1:0]          c_q, c_d;
    logic [X_W-1:0]          x0_q, x_q, x_d;
    logic [Y_W-1:0]          y0_q, y_q, y_d;
    logic                    plot_q, blank_q;
    logic                    dab_load, dab_busy, dab_valid;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [3:0]              cur_dig;
    logic [NUM_DIGITS-1:0]   blank_vec;
    logic                    lead_zero, cur_blank;
    logic [ROM_AW-1:0]       addr;

    bcd_dabble #(
        .SCORE_W   (SCORE_W),
        .NUM_DIGITS(NUM_DIGITS)
    ) u_dabble (
        .clock  (clock),
        .reset  (reset),
        .load_i (dab_load),
        .bin_i  (score),
        .busy_o (dab_busy),
        .valid_o(dab_valid),
        .bcd_o  (bcd)
    );

    always_comb begin
        state_d  = state_q;
        d_d      = d_q;
        r_d      = r_q;
        c_d      = c_q;
        dab_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dab_load = 1'b1;
                    state_d  = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (dab_busy && dab_valid) begin
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (c_q == C_W'(GLYPH_W - 1)) begin
                    c_d = '0;
                    if (r_q == R_W'(GLYPH_H - 1)) begin
                        r_d = '0;
                        if (d_q == D_W'(NUM_DIGITS - 1)) begin
                            d_d     = '0;
                            state_d = ST_FLUSH;
                        end else begin
                            d_d = d_q + D_W'(1);
                        end
                    end else begin
                        r_d = r_q + R_W'(1);
                    end
                end else begin
                    c_d = c_q + C_W'(1);
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A digit is blanked while every digit to its left (and itself) is zero; the LSD never is.
    always_comb begin
        cur_dig   = '0;
        lead_zero = 1'b1;
        blank_vec = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lead_zero    = lead_zero && (bcd[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
            blank_vec[i] = (BLANK_LZ != 0) && lead_zero && (i < NUM_DIGITS - 1);
            if (d_q == D_W'(i)) begin
                cur_dig = bcd[4*(NUM_DIGITS-1-i) +: 4];
            end
        end
        cur_blank = blank_vec[d_q];
        addr = ROM_AW'(glyph_base(int'(cur_dig), PIX_PER_GLYPH))
             + ROM_AW'(int'(r_q) * GLYPH_W) + ROM_AW'(c_q);
        x_d  = x0_q + X_W'(int'(d_q) * (GLYPH_W + GAP)) + X_W'(c_q);
        y_d  = y0_q + Y_W'(r_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            d_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            plot_q  <= 1'b0;
            blank_q <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            r_q     <= r_d;
            c_q     <= c_d;
            if (state_q == ST_IDLE && start) begin
                x0_q <= x0;
                y0_q <= y0;
            end
            // Pixel stage lines up with the one-cycle ROM read.
            plot_q <= (state_q == ST_DRAW);
            if (state_q == ST_DRAW) begin
                x_q     <= x_d;
                y_q     <= y_d;
                blank_q <= cur_blank;
            end
        end
    end

    assign rom_addr = (state_q == ST_DRAW) ? addr : '0;
    assign x        = x_q;
    assign y        = y_q;
    assign plot     = plot_q;
    assign colour   = plot_q ? (blank_q ? BG_COLOUR : rom_q) : '0;
    assign busy     = (state_q == ST_CONVERT) || (state_q == ST_DRAW) || (state_q == ST_FLUSH);
    assign done     = (state_q == ST_DONE);

endmodule

// File: doc/score_renderer.md
Name: score_renderer

Overview:
- Multi-digit successor to the single-glyph score loader.
- Accepts a binary score and a screen origin, converts the score to BCD with a sequential double-dabble, then scans every digit glyph through the shared digit ROM.
- Emits one pixel write (x, y, colour, plot) per glyph pixel to the VGA plotter, with leading-zero blanking and saturation.
- Sits between game logic (score register) and the frame-buffer write arbiter.

Parameters:
- NUM_DIGITS, 4, digits drawn, most significant digit (MSD) first, left to right
- SCORE_W, 14, binary score width
- GLYPH_W, 16, glyph width in pixels (power of 2)
- GLYPH_H, 32, glyph height in pixels (power of 2)
- GAP, 2, blank columns between digits (never plotted)
- COLOUR_W, 3, colour bits
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- BLANK_LZ, 1, 1 = leading zeros drawn in BG_COLOUR; the least significant digit (LSD) is never blanked
- BG_COLOUR, 3'b000, colour used for blanked digits
- ROM_AW, 13, ROM address width, must be >= clog2(10*GLYPH_W*GLYPH_H)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- score  in  SCORE_W  binary value, latched on an accepted start
- x0  in  X_W  left pixel of the MSD, latched on start
- y0  in  Y_W  top pixel, latched on start
- rom_addr  out  ROM_AW  glyph ROM address
- rom_q  in  COLOUR_W  ROM data, valid exactly 1 cycle after rom_addr
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  COLOUR_W  pixel colour
- plot  out  1  pixel write strobe
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset, while low: state = IDLE; x, y, colour, rom_addr = 0; plot = busy = done = 0; BCD register cleared.
- IDLE:
  - start = 1 latches score, x0 and y0, then goes to CONVERT.
  - If score >= 10^NUM_DIGITS, the BCD value is forced to all 9s and CONVERT runs anyway, keeping timing constant.
- CONVERT:
  - Runs SCORE_W cycles of shift-add-3 double-dabble, one shift per cycle, then goes to DRAW.
  - Saturation overrides the result at the final cycle.
- DRAW:
  - Counters d (digit, 0 = MSD), r (row) and c (col) step c fastest, then r, then d.
  - rom_addr = bcd[d]*GLYPH_W*GLYPH_H + r*GLYPH_W + c, computed unsigned at ROM_AW width with no +1 offset.
  - One address is issued per cycle, for NUM_DIGITS*GLYPH_W*GLYPH_H issue cycles total.
  - After the last address, go to FLUSH.
- FLUSH: one cycle that drains the final pixel, then DONE.
- DONE: done = 1 for exactly one cycle, busy drops in the same cycle, return to IDLE.
- Pixel pipeline (1 stage, matched to ROM latency):
  - In the cycle after an address is issued: plot = 1.
  - x = x0 + d*(GLYPH_W+GAP) + c; y = y0 + r, both delayed one cycle.
  - colour = rom_q, or BG_COLOUR if the digit is blanked.
  - plot is 0 in every other cycle.
- Blanking (BLANK_LZ = 1):
  - Digit d is blanked iff all bcd digits 0..d are 0 and d < NUM_DIGITS-1.
  - Score 0 therefore draws the final "0" normally.
- Coordinates: addition is truncated to X_W/Y_W and wraps silently. Keeping the block on screen is the caller's job.
- Total latency from start to done: 1 + SCORE_W + N_pix + 1 + 1 cycles, where N_pix = NUM_DIGITS*GLYPH_W*GLYPH_H.
- start while busy: ignored, with no effect on the latched values.
- Reset mid-operation: immediate abort to IDLE. plot is deasserted asynchronously and no further pixels are issued.
- score and x0/y0 changing after start: no effect until the next accepted start.

Decomposition:
- Shared package score_pkg:
  - state enum (IDLE, CONVERT, DRAW, FLUSH, DONE)
  - function pow10(NUM_DIGITS) for the saturation threshold
  - function glyph_base(digit) = digit*GLYPH_W*GLYPH_H
- One natural sub-module, bcd_dabble:
  - Sequential double-dabble, parametrised by SCORE_W and NUM_DIGITS.
  - Handshake: load/busy/valid, output bcd[4*NUM_DIGITS-1:0].
- The ROM stays external so the bench can model it.

Test Plan:
- score=1234, x0=10, y0=5:
  - bcd = 1,2,3,4.
  - First plot (x=10, y=5) follows rom_addr=512.
  - Digit 3's first address = 2048, and its first pixel lands at x=64.
  - Exactly 2048 plots; done at cycle 1+14+2048+2 = 2065 after start.
- score=7, BLANK_LZ=1:
  - Digits 0..2 (1536 pixels) plot with colour=BG_COLOUR regardless of rom_q.
  - Digit 3 colour equals rom_q delayed one cycle, from addresses 3584..4095.
- score=0: first three digits blanked, last digit draws the "0" glyph (addresses 0..511), 2048 plots total.
- score=12000 (>= 10^4): saturates; every rom_addr lies in 4608..5119 (glyph 9); timing is identical to score=1234.
- start re-pulsed during DRAW with a different score: ignored, output stream unchanged, single done.
- reset driven low at pixel 700 of DRAW:
  - plot = 0, busy = 0 and x = y = 0 immediately.
  - After release and a new start, a full 2048-pixel frame is produced with the correct digits.
